// File: rtl/alu_rr_sched_pkg.sv
// ---------------------------------------------------------------------------
// alu_rr_sched_pkg
// Shared types and constants for the round-robin ALU scheduler.
//   ALU_IN_W / ALU_OUT_W : ALU operand and result widths
//   a_op_e / b_op_e      : ALU opcode encodings (forwarded, never decoded here)
//   alu_cmd_t            : one latched ALU command
//   sched_state_e        : scheduler FSM states
//   idx_w()              : index width helper that never returns 0
// ---------------------------------------------------------------------------
package alu_rr_sched_pkg;

  localparam int ALU_IN_W  = 5;
  localparam int ALU_OUT_W = 6;

  typedef enum logic [2:0] {
    ADD_A  = 3'd0,
    SUB_A  = 3'd1,
    AND_A  = 3'd2,
    OR_A   = 3'd3,
    XOR_A  = 3'd4,
    PASS_A = 3'd5,
    NOT_A  = 3'd6,
    NEG_A  = 3'd7
  } a_op_e;

  typedef enum logic [1:0] {
    ADDTWO_B_2 = 2'd0,
    SUBONE_B_2 = 2'd1,
    PASS_B_2   = 2'd2,
    NEG_B_2    = 2'd3
  } b_op_e;

  typedef struct packed {
    logic [ALU_IN_W-1:0] A;
    logic [ALU_IN_W-1:0] B;
    logic                a_en;
    logic                b_en;
    logic [2:0]          a_op;
    logic [1:0]          b_op;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_e;

  // Width of an index/counter able to hold 0..n-1; at least one bit so that
  // single-value ranges still give a legal vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_rr_sched_if.sv
// ---------------------------------------------------------------------------
// alu_rr_sched_if
// Bundles the requester command/response channels and the ALU port of the
// scheduler.
//   req_*  : per-requester command channel (valid/ready)
//   rsp_*  : per-requester response channel (valid/ready), shared rsp_C
//   alu_*  : operand/opcode/enable outputs to the ALU, alu_C result back
// Modports:
//   slave  : scheduler side
//   master : requester agents + ALU side
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both high for the same requester bit. Once the
// scheduler raises rsp_valid it keeps it and rsp_C stable until that
// transfer; ready never depends on anything but the scheduler's own state
// and the current valid bits.
// ---------------------------------------------------------------------------
interface alu_rr_sched_if
  import alu_rr_sched_pkg::*;
#(
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [ALU_IN_W*NUM_REQ-1:0] req_A;
  logic [ALU_IN_W*NUM_REQ-1:0] req_B;
  logic [NUM_REQ-1:0]          req_a_en;
  logic [NUM_REQ-1:0]          req_b_en;
  logic [3*NUM_REQ-1:0]        req_a_op;
  logic [2*NUM_REQ-1:0]        req_b_op;

  logic [NUM_REQ-1:0]          rsp_valid;
  logic [NUM_REQ-1:0]          rsp_ready;
  logic [ALU_OUT_W-1:0]        rsp_C;

  logic [ALU_IN_W-1:0]         alu_A;
  logic [ALU_IN_W-1:0]         alu_B;
  logic                        alu_a_en;
  logic                        alu_b_en;
  logic [2:0]                  alu_a_op;
  logic [1:0]                  alu_b_op;
  logic [ALU_OUT_W-1:0]        alu_C;

  modport slave (
    input  req_valid, req_A, req_B, req_a_en, req_b_en, req_a_op, req_b_op,
    input  rsp_ready, alu_C,
    output req_ready, rsp_valid, rsp_C,
    output alu_A, alu_B, alu_a_en, alu_b_en, alu_a_op, alu_b_op
  );

  modport master (
    output req_valid, req_A, req_B, req_a_en, req_b_en, req_a_op, req_b_op,
    output rsp_ready, alu_C,
    input  req_ready, rsp_valid, rsp_C,
    input  alu_A, alu_B, alu_a_en, alu_b_en, alu_a_op, alu_b_op
  );

endinterface

// File: rtl/alu_rr_sched_rr_arbiter.sv
// ---------------------------------------------------------------------------
// alu_rr_sched_rr_arbiter
// Combinational round-robin pick: the first set req_i bit found searching
// upward from ptr_i, wrapping modulo NUM_REQ.
//   req_i       : request vector
//   ptr_i       : highest-priority index for this pick
//   grant_o     : one-hot grant (all zero when nothing requests)
//   grant_idx_o : index of the granted bit (0 when nothing requests)
//   grant_any_o : some request was granted
// ---------------------------------------------------------------------------
module alu_rr_sched_rr_arbiter
  import alu_rr_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               grant_any_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Wrap with a subtract rather than %, valid since ptr_i < NUM_REQ.
      cand = int'(ptr_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req_i[cand_idx]) begin
        found              = 1'b1;
        grant_o[cand_idx]  = 1'b1;
        grant_idx_o        = cand_idx;
      end
    end
  end

  assign grant_any_o = found;

endmodule

// File: rtl/alu_rr_sched.sv
// ---------------------------------------------------------------------------
// alu_rr_sched
// Shares one registered ALU between NUM_REQ requesters. A command is accepted
// in IDLE, driven onto the ALU for exactly one ISSUE cycle, the result is
// captured ALU_LAT cycles after that issue edge, and then offered back to
// the owning requester until it is accepted.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : alu_rr_sched_if.slave (requester channels + ALU port)
//   busy     : high whenever the FSM is not in IDLE
//   state_o  : current FSM state, for observation
// ---------------------------------------------------------------------------
module alu_rr_sched
  import alu_rr_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ALU_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  alu_rr_sched_if.slave bus,
  output logic          busy,
  output sched_state_e  state_o
);

  localparam int               IDX_W    = idx_w(NUM_REQ);
  localparam int               LAT_W    = idx_w(ALU_LAT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ALU_LAT - 1);

  sched_state_e         state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  alu_cmd_t             cmd_q, cmd_d;
  logic [LAT_W-1:0]     lat_cnt_q, lat_cnt_d;
  logic [ALU_OUT_W-1:0] rsp_c_q, rsp_c_d;

  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_any;
  alu_cmd_t             req_cmd [NUM_REQ];

  alu_rr_sched_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i       (bus.req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_any_o (grant_any)
  );

  // Unpack the flat per-requester buses into one command per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_cmd[i].A    = bus.req_A[i*ALU_IN_W +: ALU_IN_W];
      req_cmd[i].B    = bus.req_B[i*ALU_IN_W +: ALU_IN_W];
      req_cmd[i].a_en = bus.req_a_en[i];
      req_cmd[i].b_en = bus.req_b_en[i];
      req_cmd[i].a_op = bus.req_a_op[i*3 +: 3];
      req_cmd[i].b_op = bus.req_b_op[i*2 +: 2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      cmd_q     <= '0;
      lat_cnt_q <= '0;
      rsp_c_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      cmd_q     <= cmd_d;
      lat_cnt_q <= lat_cnt_d;
      rsp_c_q   <= rsp_c_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    cmd_d     = cmd_q;
    lat_cnt_d = lat_cnt_q;
    rsp_c_d   = rsp_c_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          cmd_d    = req_cmd[grant_idx];
          owner_d  = grant_idx;
          rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        lat_cnt_d = LAT_LOAD;
        state_d   = WAIT;
      end
      WAIT: begin
        // lat_cnt reaches 0 in cycle issue+ALU_LAT, when alu_C is valid.
        if (lat_cnt_q == '0) begin
          rsp_c_d = bus.alu_C;
          state_d = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from registered state only (plus the arbiter grant in
  // IDLE), so they drop with the asynchronous reset. The ALU port is zeroed
  // outside ISSUE so the ALU never sees a stale enable.
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.alu_A     = '0;
    bus.alu_B     = '0;
    bus.alu_a_en  = 1'b0;
    bus.alu_b_en  = 1'b0;
    bus.alu_a_op  = '0;
    bus.alu_b_op  = '0;
    if (state_q == IDLE && !rst) bus.req_ready = grant;
    if (state_q == RESP) bus.rsp_valid[owner_q] = 1'b1;
    if (state_q == ISSUE) begin
      bus.alu_A    = cmd_q.A;
      bus.alu_B    = cmd_q.B;
      bus.alu_a_en = cmd_q.a_en;
      bus.alu_b_en = cmd_q.b_en;
      bus.alu_a_op = cmd_q.a_op;
      bus.alu_b_op = cmd_q.b_op;
    end
  end

  assign bus.rsp_C = rsp_c_q;
  assign busy      = (state_q != IDLE);
  assign state_o   = state_q;

endmodule

// File: tb/tb_alu_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_alu_rr_sched
// Directed bench for alu_rr_sched: an ALU_LAT=1 instance covers single ops,
// rotating contention, backpressure and mid-operation reset; an ALU_LAT=3
// instance covers the longer capture latency. A small registered ALU model
// sits on each ALU port. Inputs change on the falling edge; outputs are
// checked 1 time unit later.
// ---------------------------------------------------------------------------
module tb_alu_rr_sched;
  import alu_rr_sched_pkg::*;

  localparam int NUM_REQ = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_rr_sched_if #(.NUM_REQ(NUM_REQ)) bus ();
  alu_rr_sched_if #(.NUM_REQ(NUM_REQ)) bus3 ();
  logic         busy, busy3;
  sched_state_e state, state3;

  alu_rr_sched #(.NUM_REQ(NUM_REQ), .ALU_LAT(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy),
    .state_o (state)
  );

  alu_rr_sched #(.NUM_REQ(NUM_REQ), .ALU_LAT(3)) dut3 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus3),
    .busy    (busy3),
    .state_o (state3)
  );

  // ---------------- ALU model ----------------
  // Operands sign-extended to 6 bits; the b path wins when both are enabled.
  function automatic logic [5:0] alu_f(input logic [4:0] a, input logic [4:0] b,
                                       input logic ae, input logic be,
                                       input logic [2:0] aop, input logic [1:0] bop);
    logic signed [5:0] sa, sb;
    sa = {a[4], a};
    sb = {b[4], b};
    alu_f = '0;
    if (be) begin
      case (bop)
        ADDTWO_B_2: alu_f = sb + 6'sd2;
        SUBONE_B_2: alu_f = sb - 6'sd1;
        PASS_B_2:   alu_f = sb;
        default:    alu_f = -sb;
      endcase
    end else if (ae) begin
      case (aop)
        ADD_A:   alu_f = sa + sb;
        SUB_A:   alu_f = sa - sb;
        AND_A:   alu_f = sa & sb;
        default: alu_f = sa | sb;
      endcase
    end
  endfunction

  logic [5:0] alu1_q = '0;
  always @(posedge clk)
    if (bus.alu_a_en | bus.alu_b_en)
      alu1_q <= alu_f(bus.alu_A, bus.alu_B, bus.alu_a_en, bus.alu_b_en,
                      bus.alu_a_op, bus.alu_b_op);
  assign bus.alu_C = alu1_q;

  logic [5:0] alu3_s1 = '0, alu3_s2 = '0, alu3_s3 = '0;
  always @(posedge clk) begin
    if (bus3.alu_a_en | bus3.alu_b_en)
      alu3_s1 <= alu_f(bus3.alu_A, bus3.alu_B, bus3.alu_a_en, bus3.alu_b_en,
                       bus3.alu_a_op, bus3.alu_b_op);
    alu3_s2 <= alu3_s1;
    alu3_s3 <= alu3_s2;
  end
  assign bus3.alu_C = alu3_s3;

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [5:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compares rsp_valid and rsp_C against the head of the expected queue;
  // pop removes the entry once its handshake is being driven.
  task automatic check_rsp(input string tag, input logic [1:0] vld, input bit pop);
    logic [5:0] e;
    e = (exp_q.size() > 0) ? exp_q[0] : 6'bx;
    check({tag, "_vld"}, bus.rsp_valid, vld);
    check({tag, "_c"}, bus.rsp_C, e);
    if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input logic [4:0] a, input logic [4:0] b,
                         input logic ae, input logic be,
                         input logic [2:0] aop, input logic [1:0] bop);
    bus.req_A[r*5 +: 5]    = a;
    bus.req_B[r*5 +: 5]    = b;
    bus.req_a_en[r]        = ae;
    bus.req_b_en[r]        = be;
    bus.req_a_op[r*3 +: 3] = aop;
    bus.req_b_op[r*2 +: 2] = bop;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    bus.req_valid = '0;  bus.req_A = '0;    bus.req_B = '0;
    bus.req_a_en  = '0;  bus.req_b_en = '0; bus.req_a_op = '0; bus.req_b_op = '0;
    bus.rsp_ready = '0;
    bus3.req_valid = '0; bus3.req_A = '0;    bus3.req_B = '0;
    bus3.req_a_en  = '0; bus3.req_b_en = '0; bus3.req_a_op = '0; bus3.req_b_op = '0;
    bus3.rsp_ready = '0;

    cyc(); cyc(); #1;
    check("rst_state", state, IDLE);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_alu_en", {bus.alu_a_en, bus.alu_b_en}, 0);
    check("rst_rsp_c", bus.rsp_C, 0);
    check("rst_state3", state3, IDLE);
    cyc(); rst = 1'b0;

    // Single op, requester 0: 3 + 4 = 7
    cyc();
    set_req(0, 5'd3, 5'd4, 1'b1, 1'b0, ADD_A, 2'd0);
    bus.req_valid = 2'b01; bus.rsp_ready = 2'b01;
    exp_q.push_back(6'd7);
    #1 check("t1_req_ready", bus.req_ready, 2'b01);
    check("t1_idle_busy", busy, 0);
    cyc(); bus.req_valid = 2'b00;
    #1 check("t1_issue_state", state, ISSUE);
    check("t1_alu_a_en", bus.alu_a_en, 1);
    check("t1_alu_b_en", bus.alu_b_en, 0);
    check("t1_alu_A", bus.alu_A, 3);
    check("t1_alu_B", bus.alu_B, 4);
    check("t1_alu_a_op", bus.alu_a_op, ADD_A);
    check("t1_busy", busy, 1);
    check("t1_issue_ready", bus.req_ready, 0);
    cyc(); #1;
    check("t1_wait_state", state, WAIT);
    check("t1_alu_a_en_off", bus.alu_a_en, 0);
    check("t1_alu_A_off", bus.alu_A, 0);
    check("t1_wait_rsp", bus.rsp_valid, 0);
    cyc(); #1 check_rsp("t1_rsp", 2'b01, 1'b1);
    cyc(); #1;
    check("t1_done_valid", bus.rsp_valid, 0);
    check("t1_done_busy", busy, 0);

    // Signed subtract, requester 1: 2 - 5 = -3
    cyc();
    set_req(1, 5'd2, 5'd5, 1'b1, 1'b0, SUB_A, 2'd0);
    bus.req_valid = 2'b10; bus.rsp_ready = 2'b10;
    exp_q.push_back(6'h3D);
    #1 check("t2_req_ready", bus.req_ready, 2'b10);
    cyc(); bus.req_valid = 2'b00;
    #1 check("t2_alu_a_op", bus.alu_a_op, SUB_A);
    check("t2_alu_A", bus.alu_A, 2);
    cyc(); cyc();
    #1 check_rsp("t2_rsp", 2'b10, 1'b1);
    cyc(); #1 check("t2_done_state", state, IDLE);

    // Contention: both valid continuously, grants 0,1,0,1 every 4 cycles
    cyc();
    set_req(0, 5'd0, 5'h1F, 1'b1, 1'b1, ADD_A, ADDTWO_B_2);
    set_req(1, 5'd0, 5'd3,  1'b1, 1'b1, ADD_A, ADDTWO_B_2);
    bus.req_valid = 2'b11; bus.rsp_ready = 2'b11;
    for (int n = 0; n < 4; n++) begin
      logic [1:0] oh;
      oh = (n % 2 == 0) ? 2'b01 : 2'b10;
      exp_q.push_back((n % 2 == 0) ? 6'd1 : 6'd5);
      #1 check($sformatf("t3_grant%0d", n), bus.req_ready, oh);
      cyc(); #1 check($sformatf("t3_issue_ready%0d", n), bus.req_ready, 0);
      cyc(); cyc();
      #1 check_rsp($sformatf("t3_rsp%0d", n), oh, 1'b1);
      cyc();
    end
    bus.req_valid = 2'b00;

    // Backpressure: requester 0 held in RESP for 10 cycles, requester 1 waits
    cyc();
    set_req(0, 5'd0, 5'd0, 1'b0, 1'b1, ADD_A, SUBONE_B_2);
    set_req(1, 5'd1, 5'd1, 1'b1, 1'b0, ADD_A, 2'd0);
    bus.req_valid = 2'b11; bus.rsp_ready = 2'b00;
    exp_q.push_back(6'h3F);
    #1 check("t4_grant", bus.req_ready, 2'b01);
    cyc(); bus.req_valid = 2'b10;
    #1 check("t4_alu_b_en", bus.alu_b_en, 1);
    check("t4_alu_b_op", bus.alu_b_op, SUBONE_B_2);
    cyc(); cyc();
    for (int i = 0; i < 10; i++) begin
      #1 check_rsp($sformatf("t4_hold%0d", i), 2'b01, 1'b0);
      check($sformatf("t4_ready%0d", i), bus.req_ready, 0);
      check($sformatf("t4_alu_en%0d", i), {bus.alu_a_en, bus.alu_b_en}, 0);
      cyc();
    end
    bus.rsp_ready = 2'b10;
    #1 check("t4_nonowner", bus.rsp_valid, 2'b01);
    cyc(); #1 check("t4_still_resp", state, RESP);
    bus.rsp_ready = 2'b01;
    bus.req_valid = 2'b01;
    set_req(0, 5'd1, 5'd1, 1'b1, 1'b0, ADD_A, 2'd0);
    #1 check_rsp("t4_release", 2'b01, 1'b1);

    // Reset mid-op: requester 0 accepted (pointer moves to 1), reset in WAIT
    cyc();
    #1 check("t5_grant", bus.req_ready, 2'b01);
    check("t5_rsp_off", bus.rsp_valid, 0);
    cyc(); bus.req_valid = 2'b00;
    #1 check("t5_issue", state, ISSUE);
    cyc(); #1 check("t5_wait", state, WAIT);
    cyc(); rst = 1'b1; bus.req_valid = 2'b11; bus.rsp_ready = 2'b11;
    #1;
    check("t5_rst_state", state, IDLE);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_rsp", bus.rsp_valid, 0);
    check("t5_rst_ready", bus.req_ready, 0);
    check("t5_rst_alu", {bus.alu_a_en, bus.alu_b_en}, 0);
    check("t5_rst_rsp_c", bus.rsp_C, 0);
    cyc(); rst = 1'b0; bus.req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("t5_quiet%0d", i), bus.rsp_valid, 0);
      check($sformatf("t5_quiet_busy%0d", i), busy, 0);
      cyc();
    end
    bus.req_valid = 2'b11;
    exp_q.push_back(6'd2);
    #1 check("t5_regrant", bus.req_ready, 2'b01);
    cyc(); bus.req_valid = 2'b00;
    cyc(); cyc();
    #1 check_rsp("t5_rsp", 2'b01, 1'b1);
    cyc(); #1 check("t5_done", state, IDLE);

    // ALU_LAT=3 instance: 10 + 5 = 15, response at cycle 5
    cyc();
    bus3.req_A = {5'd0, 5'd10}; bus3.req_B = {5'd0, 5'd5};
    bus3.req_a_en = 2'b01; bus3.req_a_op = {3'd0, ADD_A};
    bus3.req_valid = 2'b01; bus3.rsp_ready = 2'b01;
    #1 check("l3_grant", bus3.req_ready, 2'b01);
    cyc(); bus3.req_valid = 2'b00;
    #1 check("l3_issue", state3, ISSUE);
    check("l3_alu_a_en", bus3.alu_a_en, 1);
    for (int i = 2; i <= 4; i++) begin
      cyc();
      #1 check($sformatf("l3_wait%0d", i), state3, WAIT);
      check($sformatf("l3_norsp%0d", i), bus3.rsp_valid, 0);
    end
    cyc();
    #1 check("l3_rsp_valid", bus3.rsp_valid, 2'b01);
    check("l3_rsp_c", bus3.rsp_C, 6'd15);
    cyc(); #1 check("l3_done", state3, IDLE);

    check("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_rr_sched.md
Name: alu_rr_sched

Overview:
Round-robin scheduler that shares one registered ALU (5-bit operands, 6-bit result, fixed latency) between NUM_REQ requesters. It accepts a command from one requester per valid/ready handshake and drives the ALU operand and opcode ports for exactly one cycle. It then captures the ALU result after ALU_LAT cycles and returns it to the owning requester over a valid/ready response channel. The block sits between the requester agents and the ALU.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ALU_LAT, 1, cycles from the ALU issue edge to a valid C (1..4)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  per-requester command valid
req_ready  out  NUM_REQ  per-requester command accept; at most one bit high
req_A  in  5*NUM_REQ  operand A, requester i at bits [5i+4:5i]
req_B  in  5*NUM_REQ  operand B, same packing as req_A
req_a_en  in  NUM_REQ  a_en per requester
req_b_en  in  NUM_REQ  b_en per requester
req_a_op  in  3*NUM_REQ  a_op per requester
req_b_op  in  2*NUM_REQ  b_op per requester
rsp_valid  out  NUM_REQ  result valid, owner bit only
rsp_ready  in  NUM_REQ  result accept
rsp_C  out  6  result data, shared by all requesters
alu_A, alu_B  out  5  to ALU operand ports
alu_a_en, alu_b_en  out  1  to ALU enable ports
alu_a_op  out  3  to ALU a_op port
alu_b_op  out  2  to ALU b_op port
alu_C  in  6  from ALU result port
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. On rst: state=IDLE, rr_ptr=0, all outputs 0.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req_valid bit is high, grant g = first set bit searching from rr_ptr upward, modulo NUM_REQ.
  - req_ready[g]=1 combinationally in the same cycle.
  - Latch the command and owner=g. Set rr_ptr=(g+1)%NUM_REQ. Next state ISSUE.
  - req_ready is 0 in every state other than IDLE.
- ISSUE (exactly 1 cycle):
  - alu_* ports carry the latched command.
  - Load lat_cnt=ALU_LAT-1. Next state WAIT.
- WAIT:
  - If lat_cnt==0, capture alu_C into rsp_C and go to RESP. Otherwise decrement lat_cnt.
  - Capture therefore happens on the edge ending cycle t+ALU_LAT, where t is the ISSUE cycle.
- alu_* ports outside ISSUE: alu_a_en=alu_b_en=0 and all other alu_* outputs = 0, so the ALU is never re-enabled with stale data.
- RESP:
  - rsp_valid[owner]=1. rsp_C is held stable until rsp_ready[owner]=1.
  - On that handshake, rsp_valid goes to 0 next cycle and the state returns to IDLE.
  - rsp_ready bits of non-owners are ignored.
- Latency: accept at cycle 0 gives rsp_valid at cycle ALU_LAT+2 (cycle 3 when ALU_LAT=1). Minimum issue interval is ALU_LAT+3 cycles.
- The command is forwarded unmodified. {a_en,b_en}=00 is forwarded as-is, and the result is whatever the ALU produces. The scheduler does no arithmetic or width change.
- req_valid changing while not granted is legal. A request dropped before its grant is never issued.
- Simultaneous requests: rotating priority. With both requesters continuously valid, grants alternate 0,1,0,1.
- rsp_ready held low: the scheduler stalls in RESP indefinitely. req_ready stays 0, and the ALU stays disabled.
- Reset mid-operation: the in-flight command is dropped with no response. rsp_valid and busy fall asynchronously.

Decomposition:
- Package p_headers gains:
  - alu_cmd_t, a packed struct {A[4:0], B[4:0], a_en, b_en, a_op[2:0], b_op[1:0]}.
  - sched_state_e {IDLE, ISSUE, WAIT, RESP}.
  - Width constants ALU_IN_W=5 and ALU_OUT_W=6.
- Existing opcode enums (ADD_A, SUB_A, ADDTWO_B_2, ...) are reused.
- One sub-module, rr_arbiter: combinational grant from req_valid and rr_ptr, outputting a one-hot grant and its index.

Test Plan:
- Single op: requester 0 sends A=5'd3, B=5'd4, a_en=1, b_en=0, a_op=ADD_A, with rsp_ready=1 -> alu_a_en=1 for one cycle only; rsp_valid[0] at cycle 3; rsp_C=6'd7.
- Signed subtract: requester 1 sends A=5'd2, B=5'd5, SUB_A -> rsp_valid[1] only; rsp_C=6'h3D (-3).
- Contention: both requesters valid every cycle with ADDTWO_B_2 (a_en=b_en=1):
  - requester 0 has B=5'h1F; requester 1 has B=5'd3.
  - Expected: grants alternate 0,1,0,1; rsp_C alternates 6'd1 and 6'd5; each issue interval is 4 cycles.
- Backpressure: requester 0 SUBONE_B_2 with A=5'd0, rsp_ready held 0 for 10 cycles -> rsp_valid[0] and rsp_C=6'h3F stay stable; req_ready stays 0 for requester 1; alu_a_en=alu_b_en=0 throughout.
- Reset mid-op: assert rst during WAIT -> all outputs 0 immediately; no rsp_valid after release; next grant goes to requester 0.
- ALU_LAT=3 build: a single ADD_A accepted at cycle 0 -> capture edge ends cycle 4; rsp_valid at cycle 5.
